// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped data cache: FSM states, tag-width helper
// and the per-line {valid, tag} record.
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOOKUP  = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      WR_REQ  = 3'd4
   } state_t;

   // Line record carries tags up to TAG_MAX bits; narrower tags are zero-extended.
   localparam int TAG_MAX = 32;

   typedef struct packed {
      logic               valid;
      logic [TAG_MAX-1:0] tag;
   } line_t;

   function automatic int tag_width(input int asize, input int index);
      return asize - index;
   endfunction

endpackage

// File: rtl/cache_tag_array.sv
// Valid+tag storage for the direct-mapped cache: combinational read and hit
// compare, synchronous refill write, single-cycle invalidate of every line.
module cache_tag_array
   import cache_pkg::*;
#(
   parameter int INDEX = 4,
   parameter int TW    = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             we,
   input  logic [INDEX-1:0] idx,
   input  logic [TW-1:0]    tag,
   output logic             hit
);

   localparam int LINES = 1 << INDEX;

   line_t              lines_q [LINES];
   logic [TAG_MAX-1:0] tag_ext;

   assign tag_ext = TAG_MAX'(tag);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < LINES; i++) lines_q[i].valid <= 1'b0;
      end else if (we) begin
         lines_q[idx] <= '{valid: 1'b1, tag: tag_ext};
      end
   end

   assign hit = lines_q[idx].valid && (lines_q[idx].tag == tag_ext);

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a refill FSM
// toward a ready/valid backing memory and saturating hit/miss counters.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a request or a flush
//   LOOKUP  | compare tag; read hit responds here, write hit updates data
//   RD_REQ  | read miss: present address to memory until accepted
//   RD_WAIT | wait for read data, refill line and respond
//   WR_REQ  | post write-through to memory, respond on acceptance
module dm_cache
   import cache_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int ASIZE = 16,
   parameter int INDEX = 4,
   parameter int CNTW  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [ASIZE-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_hit,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic             mem_we,
   output logic [ASIZE-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_resp_valid,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [CNTW-1:0]  hit_count,
   output logic [CNTW-1:0]  miss_count
);

   localparam int TW    = tag_width(ASIZE, INDEX);
   localparam int LINES = 1 << INDEX;

   state_t           state_q, state_d;
   logic [ASIZE-1:0] addr_q;
   logic             we_q;
   logic [WIDTH-1:0] wdata_q;
   logic             hit_q;
   logic [WIDTH-1:0] data_q [LINES];

   logic [INDEX-1:0] idx;
   logic [TW-1:0]    tag;
   logic             hit;
   logic             accept;
   logic             flush_en;
   logic             refill;

   assign idx       = addr_q[INDEX-1:0];
   assign tag       = addr_q[ASIZE-1:INDEX];
   assign req_ready = (state_q == IDLE) && !flush && !rst;
   assign accept    = req_valid && req_ready;
   assign flush_en  = (state_q == IDLE) && flush && !rst;
   assign refill    = (state_q == RD_WAIT) && mem_resp_valid && !rst;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   cache_tag_array #(.INDEX(INDEX), .TW(TW)) u_tags (
      .clk   (clk),
      .rst   (rst),
      .flush (flush_en),
      .we    (refill),
      .idx   (idx),
      .tag   (tag),
      .hit   (hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         hit_q      <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
         end
         if (state_q == LOOKUP) begin
            hit_q <= hit;
            if (hit) begin
               if (hit_count != '1) hit_count <= hit_count + CNTW'(1);
            end else begin
               if (miss_count != '1) miss_count <= miss_count + CNTW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if ((state_q == LOOKUP) && we_q && hit) data_q[idx] <= wdata_q;
         if (refill) data_q[idx] <= mem_rdata;
      end
   end

   always_comb begin
      state_d       = state_q;
      resp_valid    = 1'b0;
      resp_hit      = 1'b0;
      resp_rdata    = '0;
      mem_req_valid = 1'b0;
      mem_we        = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = LOOKUP;
         end
         LOOKUP: begin
            if (we_q) begin
               state_d = WR_REQ;
            end else if (hit) begin
               resp_valid = 1'b1;
               resp_hit   = 1'b1;
               resp_rdata = data_q[idx];
               state_d    = IDLE;
            end else begin
               state_d = RD_REQ;
            end
         end
         RD_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_resp_valid) begin
               resp_valid = 1'b1;
               resp_rdata = mem_rdata;
               state_d    = IDLE;
            end
         end
         WR_REQ: begin
            mem_req_valid = 1'b1;
            mem_we        = 1'b1;
            if (mem_req_ready) begin
               resp_valid = 1'b1;
               resp_hit   = hit_q;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // reset aborts whatever is in flight without a response
      if (rst) begin
         resp_valid    = 1'b0;
         resp_hit      = 1'b0;
         resp_rdata    = '0;
         mem_req_valid = 1'b0;
         mem_we        = 1'b0;
      end
   end

endmodule

// File: tb/tb_dm_cache.sv
// Directed bench for dm_cache: a small in-bench memory responder drives each
// transaction and every result is compared against hand-computed values.
module tb_dm_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_hit;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_resp_valid;
   logic [63:0] mem_rdata;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int n_chk  = 0;
   int n_fail = 0;

   // transaction results
   logic        t_hit;
   logic [63:0] t_rdata;
   int          t_rcyc;
   int          t_nresp;
   logic        t_mwe;
   logic [15:0] t_maddr;
   logic [63:0] t_mwdata;
   int          t_mreq;
   logic        t_unstable;
   logic        t_rdy_seen;
   logic        busy_seen;

   always #5 clk = ~clk;

   dm_cache dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_hit       (resp_hit),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_resp_valid (mem_resp_valid),
      .mem_rdata      (mem_rdata),
      .hit_count      (hit_count),
      .miss_count     (miss_count)
   );

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One request from IDLE through its response, plus one extra cycle to catch
   // a second response. Memory accepts after rdy_dly stalled cycles and returns
   // mval the cycle after accepting a read.
   task automatic xact(input logic we, input logic [15:0] addr, input logic [63:0] wdata,
                       input logic [63:0] mval, input int rdy_dly);
      logic rd_pend;
      int   waitn;
      rd_pend = 1'b0; waitn = 0;
      t_hit = 1'b0; t_rdata = '0; t_rcyc = -1; t_nresp = 0;
      t_mwe = 1'b0; t_maddr = '0; t_mwdata = '0; t_mreq = 0;
      t_unstable = 1'b0; t_rdy_seen = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 0; c < 60; c++) begin
         mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
         if (rd_pend) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = mval;
         end
         #1;
         if (t_rcyc < 0 && req_ready) t_rdy_seen = 1'b1;
         if (mem_req_valid) begin
            if (t_mreq == 0) begin
               t_mwe = mem_we; t_maddr = mem_addr; t_mwdata = mem_wdata;
            end else if (mem_addr !== t_maddr || mem_we !== t_mwe || mem_wdata !== t_mwdata) begin
               t_unstable = 1'b1;
            end
            t_mreq++;
            if (waitn >= rdy_dly) begin
               mem_req_ready = 1'b1;
               if (!mem_we) rd_pend = 1'b1;
            end else begin
               waitn++;
            end
            #1;
         end
         if (resp_valid) begin
            t_nresp++;
            if (t_rcyc < 0) begin
               t_rcyc = c; t_hit = resp_hit; t_rdata = resp_rdata;
            end
         end
         @(negedge clk);
         if (t_rcyc >= 0 && c > t_rcyc) break;
      end
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [63:0] mval,
                         input logic exp_hit, input logic [63:0] exp_data);
      xact(1'b0, addr, '0, mval, 0);
      chk_val({tag, "_nresp"}, 64'(t_nresp), 64'd1);
      chk_val({tag, "_hit"}, {63'd0, t_hit}, {63'd0, exp_hit});
      chk_val({tag, "_rdata"}, t_rdata, exp_data);
      chk_val({tag, "_lat"}, 64'(t_rcyc), exp_hit ? 64'd0 : 64'd2);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_addr = '0; req_wdata = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      chk_val("rst_req_ready", {63'd0, req_ready}, 64'd0);
      rst = 1'b0;
      #1;
      chk_val("rst_req_ready_after", {63'd0, req_ready}, 64'd1);
      chk_val("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk_val("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
      chk_val("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk_val("rst_mem_wdata", mem_wdata, 64'd0);
      chk_val("rst_hit_count", 64'(hit_count), 64'd0);
      chk_val("rst_miss_count", 64'(miss_count), 64'd0);

      // cold miss then hit
      rd_chk("rd13_miss", 16'h0013, 64'hAAAA, 1'b0, 64'hAAAA);
      chk_val("rd13_maddr", 64'(t_maddr), 64'h13);
      chk_val("rd13_mwe", {63'd0, t_mwe}, 64'd0);
      chk_val("miss_cnt1", 64'(miss_count), 64'd1);
      rd_chk("rd13_hit", 16'h0013, 64'h0, 1'b1, 64'hAAAA);
      chk_val("rd13_hit_nomem", 64'(t_mreq), 64'd0);
      chk_val("hit_cnt1", 64'(hit_count), 64'd1);

      // conflict eviction on index 3
      rd_chk("rd23_miss", 16'h0023, 64'hBBBB, 1'b0, 64'hBBBB);
      rd_chk("rd13_evicted", 16'h0013, 64'hAAAA, 1'b0, 64'hAAAA);
      chk_val("miss_cnt3", 64'(miss_count), 64'd3);

      // write hit updates line and writes through
      xact(1'b1, 16'h0013, 64'h55, 64'h0, 0);
      chk_val("wr13_nresp", 64'(t_nresp), 64'd1);
      chk_val("wr13_hit", {63'd0, t_hit}, 64'd1);
      chk_val("wr13_rdata", t_rdata, 64'd0);
      chk_val("wr13_mwe", {63'd0, t_mwe}, 64'd1);
      chk_val("wr13_maddr", 64'(t_maddr), 64'h13);
      chk_val("wr13_mwdata", t_mwdata, 64'h55);
      chk_val("hit_cnt2", 64'(hit_count), 64'd2);
      rd_chk("rd13_after_wr", 16'h0013, 64'h0, 1'b1, 64'h55);

      // write miss does not allocate
      xact(1'b1, 16'h0044, 64'h77, 64'h0, 0);
      chk_val("wr44_hit", {63'd0, t_hit}, 64'd0);
      chk_val("wr44_mwdata", t_mwdata, 64'h77);
      rd_chk("rd44_miss", 16'h0044, 64'h1234, 1'b0, 64'h1234);
      chk_val("miss_cnt5", 64'(miss_count), 64'd5);

      // memory stalls 5 cycles before accepting
      xact(1'b0, 16'h0035, 64'hDEAD, 64'hDEAD, 5);
      chk_val("stall_nresp", 64'(t_nresp), 64'd1);
      chk_val("stall_rdata", t_rdata, 64'hDEAD);
      chk_val("stall_stable", {63'd0, t_unstable}, 64'd0);
      chk_val("stall_req_ready", {63'd0, t_rdy_seen}, 64'd0);
      chk_val("stall_mreq_cycles", 64'(t_mreq), 64'd6);
      chk_val("stall_lat", 64'(t_rcyc), 64'd7);
      chk_val("stall_maddr", 64'(t_maddr), 64'h35);

      // flush wins over a simultaneous request
      @(negedge clk);
      flush = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0013;
      #1;
      chk_val("flush_req_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0;
      busy_seen = 1'b0;
      repeat (3) begin
         #1;
         if (resp_valid || mem_req_valid) busy_seen = 1'b1;
         @(negedge clk);
      end
      chk_val("flush_no_accept", {63'd0, busy_seen}, 64'd0);
      chk_val("flush_hit_cnt", 64'(hit_count), 64'd3);
      chk_val("flush_miss_cnt", 64'(miss_count), 64'd6);
      rd_chk("rd13_post_flush", 16'h0013, 64'h5555, 1'b0, 64'h5555);
      chk_val("miss_cnt7", 64'(miss_count), 64'd7);

      // reset in RD_WAIT while memory returns data
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0066;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      #1;
      chk_val("rdreq_valid", {63'd0, mem_req_valid}, 64'd1);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 64'h9999;
      #1;
      chk_val("rstwait_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk_val("rstwait_req_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
      mem_resp_valid = 1'b0; mem_rdata = '0;
      #1;
      chk_val("rstwait_hit_cnt", 64'(hit_count), 64'd0);
      chk_val("rstwait_miss_cnt", 64'(miss_count), 64'd0);
      rst = 1'b0;
      #1;
      chk_val("rstwait_ready_after", {63'd0, req_ready}, 64'd1);
      rd_chk("rd13_post_rst", 16'h0013, 64'hAAAA, 1'b0, 64'hAAAA);
      rd_chk("rd66_post_rst", 16'h0066, 64'h6666, 1'b0, 64'h6666);
      chk_val("post_rst_miss_cnt", 64'(miss_count), 64'd2);
      chk_val("post_rst_hit_cnt", 64'(hit_count), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dm_cache.md
# dm_cache

Parametrised direct-mapped, write-through, no-write-allocate cache with a valid bit per line, a miss refill state machine and a ready/valid backing-memory port. It replaces the fixed 64-bit, hit/miss-only cache wrapper as the CPU-side data cache. It sits between a single requester and the backing memory controller, and it exports hit and miss counters for performance monitoring.

## Interface
- WIDTH, 64, data word width in bits
- ASIZE, 16, word-address width in bits
- INDEX, 4, index bits; the cache has 2^INDEX single-word lines; tag width TW = ASIZE-INDEX (INDEX < ASIZE)
- CNTW, 32, counter width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  invalidate all lines (accepted only in IDLE)
- req_valid  in  1  request present
- req_ready  out  1  cache accepts the request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ASIZE  word address
- req_wdata  in  WIDTH  write data
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  WIDTH  read data; 0 for writes
- resp_hit  out  1  1 if the request hit
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts the request
- mem_we  out  1  memory write
- mem_addr  out  ASIZE  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_resp_valid  in  1  read data return (reads only)
- mem_rdata  in  WIDTH  returned data
- hit_count, miss_count  out  CNTW  saturating counters

## Operation
- States: IDLE, LOOKUP, RD_REQ, RD_WAIT, WR_REQ.
- req_ready = (state==IDLE) & !flush & !rst. A request is accepted when req_valid & req_ready; addr, we and wdata are registered and the FSM moves to LOOKUP.
- Flush in IDLE clears every valid bit in one cycle and has priority over a request. Flush outside IDLE is ignored.
- LOOKUP: hit = valid[idx] & (tag[idx]==addr tag), where idx = addr[INDEX-1:0] and tag = addr[ASIZE-1:INDEX].
  - Read hit: resp_valid=1, resp_hit=1, resp_rdata=data[idx]; hit_count increments; next state IDLE.
  - Read miss: miss_count increments; next state RD_REQ.
  - Write, hit or miss: on hit, data[idx] is updated (tag and valid unchanged); the hit or miss counter increments; next state WR_REQ. A write miss never allocates.
- RD_REQ: mem_req_valid=1, mem_we=0, mem_addr=addr. On mem_req_ready the FSM moves to RD_WAIT.
- RD_WAIT: on mem_resp_valid:
  - data[idx]=mem_rdata, tag[idx]=addr tag, valid[idx]=1;
  - resp_valid=1, resp_hit=0, resp_rdata=mem_rdata;
  - next state IDLE.
- WR_REQ: mem_req_valid=1, mem_we=1, mem_addr=addr, mem_wdata=wdata. On mem_req_ready the cache pulses resp_valid with resp_hit equal to the registered hit; next state IDLE. Writes are posted; memory returns no response.
- Counters saturate at 2^CNTW-1. Neither counter changes on flush.
- Memory outputs hold stable while mem_req_valid=1 and mem_req_ready=0.

## Timing
- Reset values: state IDLE, all valid bits 0, both counters 0, resp_valid=0, resp_hit=0, resp_rdata=0, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0. req_ready=0 while rst=1.
- Reset during any state aborts the operation and produces no response. The memory controller shares the same rst.
- Read-hit latency: resp_valid is high one cycle after the acceptance edge. Back-to-back hits give one response every 2 cycles.
- Read-miss latency: 2 cycles plus memory ready wait plus memory response wait. The response appears in the same cycle as mem_resp_valid.
- mem_resp_valid outside RD_WAIT is ignored.
- A read of the same index in the cycle after refill sees the new line; array writes take effect at the edge that leaves RD_WAIT.
- resp_* outputs are registered-state decodes and are valid only while resp_valid=1.

## Structure
- Package cache_pkg holds:
  - the state enum;
  - TW as a derived localparam function;
  - the line record {valid, tag}.
- Sub-module cache_tag_array holds the valid+tag storage with:
  - combinational read;
  - synchronous write;
  - a flush-all input;
  - a hit compare output.
- The data array stays inline as a register array in dm_cache.

## Test plan
- Reset, then read 0x0013 with memory returning 0xAAAA -> resp_hit=0, resp_rdata=0xAAAA, miss_count=1; a repeat read -> resp_hit=1 one cycle after accept, hit_count=1.
- Read 0x0013, then read 0x0023 (same index 3, different tag) -> both miss; 0x0023 evicts 0x0013; re-reading 0x0013 misses.
- Write 0x0013=0x55 after 0x0013 is cached -> memory sees a write of 0x55 to 0x0013 and resp_hit=1; the next read hits and returns 0x55. Write to uncached 0x0044 -> resp_hit=0, and a following read of 0x0044 misses.
- Hold mem_req_ready low for 5 cycles on a miss -> mem_addr and mem_req_valid stay stable, req_ready=0 throughout, and exactly one response follows.
- Flush in IDLE with req_valid=1 at the same time -> req_ready=0; the next read of a previously cached line misses; counters are unchanged by the flush.
- Assert rst in RD_WAIT -> no resp_valid, every line is invalid, counters are 0, and req_ready=1 in the first cycle after rst drops.
